systolic1x4_ctrl: RTL and testbench

SYSTOLIC1X4_CTRL -- requirements
Module: systolic1x4_ctrl

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/skew_line.sv | 25 ++
 rtl/systolic1x4_ctrl.sv | 137 +++++++++++++
 tb/tb_systolic1x4_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults, array latency and controller state encoding for the
// 1x4 systolic array controller.
package systolic_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_KLEN_W  = 8;
  localparam int NUM_LANES   = 4;
  localparam int ARRAY_LAT   = 5;
  localparam int FLUSH_CNT_W = $clog2(ARRAY_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

endpackage

// File: rtl/skew_line.sv
// Fixed-depth shift register used to stagger one operand lane into the array.
module skew_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage_p [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/systolic1x4_ctrl.sv
// Job controller for a 1x4 output-stationary systolic array: clears the array,
// streams skewed operand beats, waits out the array latency and holds results.
module systolic1x4_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int KLEN_W = DEF_KLEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KLEN_W-1:0] k_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a0,
  input  logic [DATA_W-1:0] in_a1,
  input  logic [DATA_W-1:0] in_a2,
  input  logic [DATA_W-1:0] in_a3,
  input  logic [DATA_W-1:0] in_b,
  output logic              arr_rst,
  output logic [DATA_W-1:0] a0,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] a3,
  output logic [DATA_W-1:0] b0,
  input  logic [ACC_W-1:0]  c0,
  input  logic [ACC_W-1:0]  c1,
  input  logic [ACC_W-1:0]  c2,
  input  logic [ACC_W-1:0]  c3,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res0,
  output logic [ACC_W-1:0]  res1,
  output logic [ACC_W-1:0]  res2,
  output logic [ACC_W-1:0]  res3
);

  state_t                 state, state_nxt;
  logic [KLEN_W-1:0]      k_len_q;
  logic [KLEN_W-1:0]      beat_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   accept;
  logic                   last_beat;
  logic                   flush_last;
  logic [DATA_W-1:0]      lane_in  [NUM_LANES];
  logic [DATA_W-1:0]      lane_out [NUM_LANES];
  logic [DATA_W-1:0]      b_p1;

  assign accept     = in_valid & in_ready;
  assign last_beat  = (beat_cnt == k_len_q - KLEN_W'(1));
  assign flush_last = (flush_cnt == FLUSH_CNT_W'(ARRAY_LAT - 1));

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_FEED);
  assign res_valid = (state == S_DONE);
  assign arr_rst   = rst | (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (k_len != '0)) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_FEED;
      S_FEED:  if (accept && last_beat) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_last) state_nxt = S_DONE;
      S_DONE:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && start && (k_len != '0)) k_len_q <= k_len;
      if (state == S_CLEAR)  beat_cnt <= '0;
      else if (accept)       beat_cnt <= beat_cnt + KLEN_W'(1);
      if (state == S_FLUSH)  flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
      else                   flush_cnt <= '0;
    end
  end

  // Stage p0 -> p1: operands enter the array; idle cycles inject zeros so
  // bubbles and flush cycles contribute nothing to the accumulators.
  assign lane_in[0] = accept ? in_a0 : '0;
  assign lane_in[1] = accept ? in_a1 : '0;
  assign lane_in[2] = accept ? in_a2 : '0;
  assign lane_in[3] = accept ? in_a3 : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    skew_line #(
      .DATA_W(DATA_W),
      .DEPTH (g + 1)
    ) u_skew (
      .clk (clk),
      .rst (rst),
      .din (lane_in[g]),
      .dout(lane_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)         b_p1 <= '0;
    else if (accept) b_p1 <= in_b;
    else             b_p1 <= '0;
  end

  assign a0 = lane_out[0];
  assign a1 = lane_out[1];
  assign a2 = lane_out[2];
  assign a3 = lane_out[3];
  assign b0 = b_p1;

  // Result capture: the last flush cycle is the first with every PE settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      res0 <= '0;
      res1 <= '0;
      res2 <= '0;
      res3 <= '0;
    end else if ((state == S_FLUSH) && flush_last) begin
      res0 <= c0;
      res1 <= c1;
      res2 <= c2;
      res3 <= c3;
    end
  end

endmodule

// File: tb/tb_systolic1x4_ctrl.sv
// Bench for systolic1x4_ctrl with a behavioural 1x4 array attached to c0..c3.
module tb_systolic1x4_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  k_len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a [4];
  logic [15:0] in_b = '0;
  logic        arr_rst;
  logic [15:0] a_o [4];
  logic [15:0] b0;
  logic [31:0] acc [4];
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_w [4];
  logic [15:0] bpe [1:3];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct packed {
    logic [7:0]               k;
    int                       gap;
    int                       lat;
    int                       hold;
    bit                       use_exp;
    logic [2:0][3:0][15:0]    a;
    logic [2:0][15:0]         b;
    logic [3:0][31:0]         exp;
  } vec_t;

  vec_t             vec [7];
  logic [3:0][31:0] sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic1x4_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a[0]), .in_a1(in_a[1]), .in_a2(in_a[2]), .in_a3(in_a[3]), .in_b(in_b),
    .arr_rst(arr_rst), .a0(a_o[0]), .a1(a_o[1]), .a2(a_o[2]), .a3(a_o[3]), .b0(b0),
    .c0(acc[0]), .c1(acc[1]), .c2(acc[2]), .c3(acc[3]),
    .res_valid(res_valid), .res_ready(res_ready),
    .res0(res_w[0]), .res1(res_w[1]), .res2(res_w[2]), .res3(res_w[3])
  );

  // Behavioural array: b ripples right one PE per cycle, each PE accumulates.
  always @(posedge clk) begin
    if (arr_rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      for (int i = 1; i < 4; i++) bpe[i] <= '0;
    end else begin
      acc[0] <= acc[0] + a_o[0] * b0;
      bpe[1] <= b0;
      acc[1] <= acc[1] + a_o[1] * bpe[1];
      bpe[2] <= bpe[1];
      acc[2] <= acc[2] + a_o[2] * bpe[2];
      bpe[3] <= bpe[2];
      acc[3] <= acc[3] + a_o[3] * bpe[3];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input int k, input int gap, input int hold,
                              input logic [15:0] va0, input logic [15:0] va1, input logic [15:0] va2,
                              input logic [15:0] vb0, input logic [15:0] vb1, input logic [15:0] vb2,
                              input logic [31:0] e);
    vec_t v;
    v = '0;
    v.k = 8'(k);
    v.gap = gap;
    v.hold = hold;
    v.lat = k + gap * (k - 1) + 7;
    v.use_exp = 1'b1;
    for (int l = 0; l < 4; l++) begin
      v.a[0][l] = va0;
      v.a[1][l] = va1;
      v.a[2][l] = va2;
      v.exp[l]  = e;
    end
    v.b[0] = vb0;
    v.b[1] = vb1;
    v.b[2] = vb2;
    return v;
  endfunction

  task automatic run_job(input int idx);
    vec_t             v;
    int               s, beat, gapc, seen;
    logic [3:0][31:0] sb, want;
    v = vec[idx];
    sb = '0;
    @(negedge clk);
    start = 1'b1;
    k_len = v.k;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    beat = 0;
    gapc = 0;
    seen = -1;
    for (int t = 0; t < 200 && seen < 0; t++) begin
      if (res_valid) begin
        seen = cyc;
      end else begin
        in_valid = 1'b0;
        if (in_ready && beat < int'(v.k)) begin
          if (gapc > 0) begin
            gapc--;
          end else begin
            for (int l = 0; l < 4; l++) begin
              in_a[l] = v.a[beat][l];
              sb[l] = sb[l] + 32'(v.a[beat][l]) * 32'(v.b[beat]);
            end
            in_b = v.b[beat];
            in_valid = 1'b1;
            beat++;
            gapc = v.gap;
            if (beat == int'(v.k)) sb_q.push_back(sb);
          end
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (seen < 0) begin
      chk($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
      return;
    end
    chk($sformatf("v%0d_latency", idx), 32'(seen - s), 32'(v.lat));
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
      want = v.exp;
    end else begin
      want = sb_q.pop_front();
    end
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("v%0d_res%0d", idx, l), res_w[l], want[l]);
      if (v.use_exp) chk($sformatf("v%0d_tab%0d", idx, l), res_w[l], v.exp[l]);
    end
    // Hold results with res_ready low; a start pulse here must be ignored.
    for (int h = 0; h < v.hold; h++) begin
      start = (h == 2);
      k_len = 8'd1;
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", idx), 32'(res_valid), 32'd1);
      chk($sformatf("v%0d_hold_res0", idx), res_w[0], want[0]);
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_idle_valid", idx), 32'(res_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_no_restart", idx), 32'(busy), 32'd0);
  endtask

  task automatic mid_feed_reset();
    int beat;
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    beat = 0;
    for (int t = 0; t < 20 && beat < 2; t++) begin
      in_valid = 1'b0;
      if (in_ready) begin
        for (int l = 0; l < 4; l++) in_a[l] = 16'd7;
        in_b = 16'd7;
        in_valid = 1'b1;
        beat++;
      end
      @(negedge clk);
    end
    if (beat < 2) chk("mid_feed_timeout", 32'(beat), 32'd2);
    chk("mid_busy_before", 32'(busy), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_arr_rst", 32'(arr_rst), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_b0", 32'(b0), 32'd0);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("mid_a%0d", l), 32'(a_o[l]), 32'd0);
      chk($sformatf("mid_res%0d", l), res_w[l], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mid_arr_rst_rel", 32'(arr_rst), 32'd0);
  endtask

  initial begin
    for (int l = 0; l < 4; l++) in_a[l] = '0;

    vec[0] = mk(1, 0, 10, 16'd5, 16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 32'd25);
    vec[1] = mk(3, 0, 0, 16'd5, 16'd10, 16'd20, 16'd5, 16'd10, 16'd20, 32'd525);
    vec[2] = mk(3, 2, 0, 16'd5, 16'd10, 16'd20, 16'd5, 16'd10, 16'd20, 32'd525);
    vec[3] = mk(2, 0, 0, 16'hFFFF, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 32'hFFFC0002);
    vec[4] = mk(2, 0, 0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd3, 16'd0, 32'd0);
    vec[4].a[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    vec[4].a[1] = {16'd40, 16'd30, 16'd20, 16'd10};
    vec[4].exp  = {32'd148, 32'd111, 32'd74, 32'd37};
    vec[5] = mk(1, 0, 0, 16'd3, 16'd0, 16'd0, 16'd4, 16'd0, 16'd0, 32'd12);
    vec[6] = mk(3, 1, 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
    vec[6].use_exp = 1'b0;
    for (int j = 0; j < 3; j++) begin
      vec[6].b[j] = 16'($urandom);
      for (int l = 0; l < 4; l++) vec[6].a[j][l] = 16'($urandom);
    end

    repeat (3) @(negedge clk);
    chk("rst_arr_rst", 32'(arr_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_b0", 32'(b0), 32'd0);
    chk("rst_a3", 32'(a_o[3]), 32'd0);
    chk("rst_res0", res_w[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_arr_rst", 32'(arr_rst), 32'd0);

    start = 1'b1;
    k_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("k0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("k0_busy2", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_job(i);
    run_job(6);
    mid_feed_reset();
    run_job(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "global timeout");
  end

endmodule
